// File: rtl/pulse_pkg.sv
// Shared constants and state encoding for the pulse interval meter.
package pulse_pkg;

  localparam int CLOCK_BIT_WIDTH_DEFAULT = 30;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge strobe generator with optional two-flop input synchronizer.
// Define PULSE_INTERVAL_METER_SYNC_EN to condition an asynchronous pulse_in.
module pulse_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic edge_strobe
);

  logic cond_pulse;
  logic prev_pulse;

`ifdef PULSE_INTERVAL_METER_SYNC_EN
  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= pulse_in;
      sync_2 <= sync_1;
    end
  end

  assign cond_pulse = sync_2;
`else
  assign cond_pulse = pulse_in;
`endif

  // Only the low-to-high transition counts, so a long high level strobes once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_pulse <= 1'b0;
    else        prev_pulse <= cond_pulse;
  end

  assign edge_strobe = cond_pulse & ~prev_pulse;

endmodule

// File: rtl/pulse_interval_meter.sv
// Measures clk cycles between successive rising edges of pulse_in, with
// valid/ready result handoff, timeout and sticky overrun. Optional macro:
// PULSE_INTERVAL_METER_SYNC_EN (synchronize pulse_in before edge detection).
module pulse_interval_meter
  import pulse_pkg::*;
#(
  parameter int CLOCK_BIT_WIDTH = CLOCK_BIT_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pulse_in,
  input  logic [CLOCK_BIT_WIDTH-1:0] timeout_clks,
  output logic [CLOCK_BIT_WIDTH-1:0] period,
  output logic                       period_valid,
  input  logic                       period_ready,
  output logic                       timeout,
  output logic                       overrun
);

  localparam logic [CLOCK_BIT_WIDTH-1:0] ONE = {{(CLOCK_BIT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CLOCK_BIT_WIDTH-1:0] MAX = '1;

  meter_state_t               state, state_next;
  logic [CLOCK_BIT_WIDTH-1:0] count, count_next;
  logic                       edge_strobe;
  logic                       capture;
  logic                       fire;

  pulse_edge_detect u_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .pulse_in    (pulse_in),
    .edge_strobe (edge_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // An edge always beats a coincident timeout; the count saturates instead of wrapping.
  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    fire       = 1'b0;
    unique case (state)
      IDLE: begin
        if (edge_strobe) begin
          state_next = MEASURE;
          count_next = ONE;
        end
      end
      MEASURE: begin
        if (edge_strobe) begin
          capture    = 1'b1;
          count_next = ONE;
        end else if ((timeout_clks != '0) && (count >= timeout_clks)) begin
          fire       = 1'b1;
          state_next = IDLE;
          count_next = '0;
        end else if (count != MAX) begin
          count_next = count + ONE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // A held result is never overwritten; a capture that finds it unconsumed is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      timeout <= fire;
      if (capture) begin
        if (!period_valid || period_ready) begin
          period       <= count;
          period_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Randomized and directed bench for pulse_interval_meter, checked against an
// edge-timestamp reference model (default width and a 4-bit saturating copy).
module tb_pulse_interval_meter;

  localparam int WB = 30;
  localparam int WS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pulse_in;
  logic [WB-1:0] timeout_clks;
  logic          period_ready;
  logic [WB-1:0] period_b;
  logic          valid_b, timeout_b, overrun_b;

  logic [WS-1:0] timeout_clks_s = '0;
  logic          ready_s = 1'b1;
  logic [WS-1:0] period_s;
  logic          valid_s, timeout_s, overrun_s;

  int checks = 0;
  int passes = 0;
  int timeouts_seen = 0;

  // Reference model: per-DUT timestamp of the last reference edge plus expected outputs.
  longint cyc;
  bit     prev_cond, s1, s2;
  bit     have_ref   [2];
  longint ref_cyc    [2];
  longint exp_period [2];
  bit     exp_valid  [2];
  bit     exp_timeout[2];
  bit     exp_overrun[2];
  longint max_count  [2];

  always #5 clk = ~clk;

  pulse_interval_meter #(.CLOCK_BIT_WIDTH(WB)) dut_big (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_in     (pulse_in),
    .timeout_clks (timeout_clks),
    .period       (period_b),
    .period_valid (valid_b),
    .period_ready (period_ready),
    .timeout      (timeout_b),
    .overrun      (overrun_b)
  );

  pulse_interval_meter #(.CLOCK_BIT_WIDTH(WS)) dut_small (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_in     (pulse_in),
    .timeout_clks (timeout_clks_s),
    .period       (period_s),
    .period_valid (valid_s),
    .period_ready (ready_s),
    .timeout      (timeout_s),
    .overrun      (overrun_s)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    else
      passes++;
  endtask

  task automatic modelReset();
    cyc = 0;
    prev_cond = 0; s1 = 0; s2 = 0;
    for (int m = 0; m < 2; m++) begin
      have_ref[m] = 0; ref_cyc[m] = 0; exp_period[m] = 0;
      exp_valid[m] = 0; exp_timeout[m] = 0; exp_overrun[m] = 0;
    end
  endtask

  // Predict the effect of one rising clk edge given the inputs presented to it.
  task automatic modelStep(input bit p, input bit rdy_b, input longint tclks_b);
    bit     cond, edge_seen, got_result, fired, rdy;
    longint elapsed, tc, result;
`ifdef PULSE_INTERVAL_METER_SYNC_EN
    cond = s2;
    s2 = s1;
    s1 = p;
`else
    cond = p;
`endif
    edge_seen = cond && !prev_cond;
    prev_cond = cond;
    for (int m = 0; m < 2; m++) begin
      rdy = (m == 0) ? rdy_b : 1'b1;
      tc  = (m == 0) ? tclks_b : 0;
      got_result = 0; fired = 0; result = 0;
      if (have_ref[m]) begin
        elapsed = cyc - ref_cyc[m];
        if (elapsed > max_count[m]) elapsed = max_count[m];
        if (edge_seen) begin
          got_result = 1; result = elapsed; ref_cyc[m] = cyc;
        end else if (tc != 0 && elapsed >= tc) begin
          fired = 1; have_ref[m] = 0;
        end
      end else if (edge_seen) begin
        have_ref[m] = 1; ref_cyc[m] = cyc;
      end
      if (got_result) begin
        if (!exp_valid[m] || rdy) begin
          exp_period[m] = result; exp_valid[m] = 1;
        end else begin
          exp_overrun[m] = 1;
        end
      end else if (exp_valid[m] && rdy) begin
        exp_valid[m] = 0;
      end
      exp_timeout[m] = fired;
    end
    cyc++;
  endtask

  task automatic checkAll();
    checkOutput("big_period",   {34'd0, period_b}, exp_period[0]);
    checkOutput("big_valid",    {63'd0, valid_b},  {63'd0, exp_valid[0]});
    checkOutput("big_timeout",  {63'd0, timeout_b}, {63'd0, exp_timeout[0]});
    checkOutput("big_overrun",  {63'd0, overrun_b}, {63'd0, exp_overrun[0]});
    checkOutput("small_period", {60'd0, period_s}, exp_period[1]);
    checkOutput("small_valid",  {63'd0, valid_s},  {63'd0, exp_valid[1]});
    checkOutput("small_timeout",{63'd0, timeout_s}, {63'd0, exp_timeout[1]});
    checkOutput("small_overrun",{63'd0, overrun_s}, {63'd0, exp_overrun[1]});
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge, check after it.
  task automatic applyStimulus(input bit p, input bit rdy, input longint tc);
    pulse_in     = p;
    period_ready = rdy;
    timeout_clks = tc[WB-1:0];
    modelStep(p, rdy, tc);
    @(negedge clk);
    if (timeout_b) timeouts_seen++;
    checkAll();
  endtask

  task automatic pulseTrain(input int gap, input int count, input bit rdy, input longint tc);
    for (int i = 0; i < count; i++) begin
      applyStimulus(1'b1, rdy, tc);
      repeat (gap - 1) applyStimulus(1'b0, rdy, tc);
    end
  endtask

  task automatic checkResetZero(input string tag);
    checkOutput({tag, "_period"},  {34'd0, period_b}, 64'd0);
    checkOutput({tag, "_valid"},   {63'd0, valid_b},  64'd0);
    checkOutput({tag, "_timeout"}, {63'd0, timeout_b}, 64'd0);
    checkOutput({tag, "_overrun"}, {63'd0, overrun_b}, 64'd0);
    checkOutput({tag, "_s_period"},{60'd0, period_s}, 64'd0);
    checkOutput({tag, "_s_valid"}, {63'd0, valid_s},  64'd0);
  endtask

  task automatic doReset(input string tag);
    rst_n    = 1'b0;
    pulse_in = 1'b0;
    #1;
    checkResetZero(tag);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    max_count[0] = (64'd1 << WB) - 1;
    max_count[1] = (64'd1 << WS) - 1;
    rst_n = 1'b0; pulse_in = 1'b0; period_ready = 1'b1; timeout_clks = '0;
    modelReset();
    @(negedge clk);
    doReset("reset_init");

    $display("[TB] pulse every 5 cycles, ready high");
    pulseTrain(5, 8, 1'b1, 0);
    checkOutput("req032_period", {34'd0, period_b}, 64'd5);
    checkOutput("req032_overrun", {63'd0, overrun_b}, 64'd0);

    $display("[TB] pulse every 5 cycles, ready low");
    pulseTrain(5, 4, 1'b0, 0);
    checkOutput("req033_period", {34'd0, period_b}, 64'd5);
    checkOutput("req033_valid", {63'd0, valid_b}, 64'd1);
    checkOutput("req033_overrun", {63'd0, overrun_b}, 64'd1);
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("req033_valid_drop", {63'd0, valid_b}, 64'd0);

    $display("[TB] timeout after 10 silent cycles");
    doReset("reset_034");
    timeouts_seen = 0;
    applyStimulus(1'b1, 1'b1, 10);
    repeat (20) applyStimulus(1'b0, 1'b1, 10);
    checkOutput("req034_timeouts", timeouts_seen, 64'd1);
    pulseTrain(3, 1, 1'b1, 10);
    repeat (3) applyStimulus(1'b0, 1'b1, 10);
    checkOutput("req034_no_result", {63'd0, valid_b}, 64'd0);

    $display("[TB] reset mid-interval");
    pulseTrain(5, 2, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    doReset("reset_035");
    pulseTrain(7, 2, 1'b0, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 0);
    checkOutput("req035_period", {34'd0, period_b}, 64'd7);
    checkOutput("req035_valid", {63'd0, valid_b}, 64'd1);

    $display("[TB] long high level then edges 6 apart");
    doReset("reset_036");
    repeat (20) applyStimulus(1'b1, 1'b1, 0);
    repeat (6) applyStimulus(1'b0, 1'b1, 0);
    pulseTrain(6, 3, 1'b1, 0);
    checkOutput("req036_period", {34'd0, period_b}, 64'd6);

    $display("[TB] edges 20 apart, saturation of the narrow meter");
    doReset("reset_037");
    pulseTrain(20, 3, 1'b1, 0);
    checkOutput("req037_small_period", {60'd0, period_s}, 64'd15);
    checkOutput("req037_big_period", {34'd0, period_b}, 64'd20);

    $display("[TB] randomized traffic");
    begin
      longint tc;
      tc = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 99) == 0) tc = ($urandom_range(0, 2) == 0) ? 0 : longint'($urandom_range(3, 40));
        if ($urandom_range(0, 399) == 0) begin
          doReset("reset_rand");
        end else begin
          applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, tc);
        end
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
